// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg
// Shared types and constants for the core-side store buffer.
//   sb_entry_t       : one buffered store (word address, data, byte mask, valid)
//   SB_DEPTH_DEFAULT : default number of buffer entries
//   MASK_*           : byte-lane masks for sb/sh/sw stores
//   merge_lanes()    : byte-wise merge of new data over old data under a mask
// ---------------------------------------------------------------------------
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  // Word-address field is sized for the widest supported AW (64); narrower
  // address widths are zero-extended so comparisons stay exact.
  localparam int SB_WA_W = 62;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  typedef struct packed {
    logic [SB_WA_W-1:0] waddr;
    logic [31:0]        data;
    logic [3:0]         mask;
    logic               valid;
  } sb_entry_t;

  // Replace the lanes of old_d selected by mask with the lanes of new_d.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_d;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_merge.sv
// ---------------------------------------------------------------------------
// sb_fwd_merge
// Purely combinational load-forwarding merge over the store-buffer ring.
//   entries_i : buffer entry array
//   head_i    : index of the oldest entry
//   waddr_i   : word address of the load
//   base_i    : data read from memory
//   data_o    : base_i with every matching buffered byte applied, youngest last
// ---------------------------------------------------------------------------
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH)
) (
  input  sb_entry_t          entries_i [DEPTH],
  input  logic [PW-1:0]      head_i,
  input  logic [SB_WA_W-1:0] waddr_i,
  input  logic [31:0]        base_i,
  output logic [31:0]        data_o
);

  // Lanes this entry contributes to the load (none when invalid or other word).
  function automatic logic [3:0] hit_mask(input sb_entry_t e,
                                          input logic [SB_WA_W-1:0] wa);
    return (e.valid && (e.waddr == wa)) ? e.mask : 4'b0000;
  endfunction

  // Walk the ring from head (oldest) so younger entries overwrite older bytes;
  // DEPTH is a power of two, so the index wraps by truncation.
  always_comb begin
    data_o = base_i;
    for (int k = 0; k < DEPTH; k++) begin
      data_o = merge_lanes(data_o,
                           entries_i[head_i + PW'(k)].data,
                           hit_mask(entries_i[head_i + PW'(k)], waddr_i));
    end
  end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// In-order write buffer between the core data port and a slower data memory.
// Stores are accepted in one cycle into a FIFO ring, drained to memory over a
// valid/ready handshake, and forwarded byte-wise to loads from the same word.
// Optional build macro: STORE_COALESCE_EN -- merge a store into the youngest
// entry of the same word when that entry is not the in-flight head.
//   clk, reset            : clock, synchronous active-low reset
//   daddr/dwdata/dwe      : core address, lane-shifted store data, byte enables
//   drdata                : load data (mem_rdata merged with buffered bytes)
//   stall                 : store not accepted this cycle
//   sb_empty              : buffer holds no entries
//   mem_raddr/mem_rdata   : combinational read path to memory
//   mem_waddr/mem_wdata/mem_we/mem_valid/mem_ready : write handshake to memory
// ---------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  input  logic [3:0]    dwe,
  output logic [DW-1:0] drdata,
  output logic          stall,
  output logic          sb_empty,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_we,
  output logic          mem_valid,
  input  logic          mem_ready
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  sb_entry_t          entries_q [DEPTH];
  sb_entry_t          entries_d [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  sb_entry_t          head_e_s;
  logic [SB_WA_W-1:0] word_s;
  logic               store_s, full_s, merge_s, enq_s, pop_s;

  assign word_s   = SB_WA_W'(daddr[AW-1:2]);
  assign store_s  = |dwe;
  assign full_s   = (count_q == CNT_FULL);
  assign head_e_s = entries_q[head_q];

`ifdef STORE_COALESCE_EN
  sb_entry_t young_s;
  // Whenever the buffer is non-empty the head is presented to memory, so the
  // youngest entry is mergeable only when it is not the head (count >= 2).
  assign young_s = entries_q[tail_q - PTR_ONE];
  assign merge_s = store_s && (count_q > CNT_ONE) && young_s.valid &&
                   (young_s.waddr == word_s);
`else
  assign merge_s = 1'b0;
`endif

  // A drain in the same cycle never frees a slot for the incoming store.
  assign enq_s     = store_s && !merge_s && !full_s;
  assign stall     = store_s && full_s && !merge_s;
  assign mem_valid = (count_q != {CW{1'b0}});
  assign pop_s     = mem_valid && mem_ready;
  assign sb_empty  = (count_q == {CW{1'b0}});

  assign mem_raddr = daddr;
  assign mem_waddr = {head_e_s.waddr[AW-3:0], 2'b00};
  assign mem_wdata = head_e_s.data;
  assign mem_we    = mem_valid ? head_e_s.mask : 4'b0000;

  sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
    .entries_i (entries_q),
    .head_i    (head_q),
    .waddr_i   (word_s),
    .base_i    (mem_rdata),
    .data_o    (drdata)
  );

  // Next-state for ring contents, pointers and occupancy count.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (pop_s) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end

    if (enq_s) begin
      entries_d[tail_q] = '{waddr: word_s, data: dwdata, mask: dwe, valid: 1'b1};
      tail_d            = tail_q + PTR_ONE;
    end else if (merge_s) begin
      entries_d[tail_q - PTR_ONE].data = merge_lanes(entries_q[tail_q - PTR_ONE].data,
                                                     dwdata, dwe);
      entries_d[tail_q - PTR_ONE].mask = entries_q[tail_q - PTR_ONE].mask | dwe;
      tail_d                           = tail_q;
    end else begin
      tail_d = tail_q;
    end

    case ({enq_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every entry (payload left as-is) so nothing
  // presented before reset can complete afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule
